// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU control unit: word width, instruction
// field positions and the control FSM state encoding.
package hack_pkg;

  localparam int WORD_W   = 16;

  // Hack instruction fields (C-instruction: 111a cccc ccdd djjj)
  localparam int C_BIT    = 15;
  localparam int A_BIT    = 12;
  localparam int COMP_MSB = 11;
  localparam int COMP_LSB = 6;
  localparam int DEST_A   = 5;
  localparam int DEST_D   = 4;
  localparam int DEST_M   = 3;
  localparam int JLT      = 2;
  localparam int JEQ      = 1;
  localparam int JGT      = 0;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

endpackage

// File: rtl/hack_jump_cond.sv
// Jump condition evaluation for Hack C-instructions: decides from the jjj
// bits and the captured ALU flags whether the branch is taken.
import hack_pkg::*;

module hack_jump_cond (
  input  logic [2:0] j,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  assign take = (j[JLT] & ng) | (j[JEQ] & zr) | (j[JGT] & ~ng & ~zr);

endmodule

// File: rtl/hack_ctrl.sv
// Multi-cycle Hack CPU control unit (FETCH/DECODE/EXEC/WB) owning PC, A and D.
// Optional feature macro HACK_CTRL_HALT_EN: a taken self-jump halts the core.
import hack_pkg::*;

module hack_ctrl #(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] pc,
  input  logic [W-1:0] instr,
  input  logic         instr_valid,
  output logic         instr_ready,
  output logic [W-1:0] alu_x,
  output logic [W-1:0] alu_y,
  output logic         zx,
  output logic         nx,
  output logic         zy,
  output logic         ny,
  output logic         f,
  output logic         no,
  input  logic [W-1:0] alu_out,
  input  logic         zr,
  input  logic         ng,
  output logic [W-1:0] addressM,
  input  logic [W-1:0] inM,
  output logic [W-1:0] outM,
  output logic         writeM,
  output logic         halted
);

`ifdef HACK_CTRL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  state_t       state;
  logic [W-1:0] ir;
  logic [W-1:0] a_reg;
  logic [W-1:0] d_reg;
  logic [W-1:0] r_reg;
  logic         z_flag;
  logic         n_flag;
  logic         halt_q;
  logic         take;

  // IR[14:13] carry no meaning in the Hack ISA.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[14:13];

  hack_jump_cond u_jump_cond (
    .j    (ir[JLT:JGT]),
    .zr   (z_flag),
    .ng   (n_flag),
    .take (take)
  );

  assign instr_ready = (state == FETCH) && !halt_q;
  assign alu_x       = d_reg;
  assign alu_y       = ir[A_BIT] ? inM : a_reg;
  assign addressM    = a_reg;
  assign outM        = r_reg;
  assign halted      = halt_q;

  // In WB, A is not yet overwritten, so addressM still shows the pre-write A.
  assign writeM = (state == WB) && ir[DEST_M];

  assign {zx, nx, zy, ny, f, no} = (state == EXEC) ? ir[COMP_MSB:COMP_LSB] : 6'b0;

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register in WB sees
    // the pre-edge A; a blocking A write would leak into the jump target.
    if (reset) begin
      state  <= FETCH;
      pc     <= '0;
      ir     <= '0;
      a_reg  <= '0;
      d_reg  <= '0;
      r_reg  <= '0;
      z_flag <= 1'b0;
      n_flag <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (instr_valid && instr_ready) begin
            ir    <= instr;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (ir[C_BIT]) begin
            state <= EXEC;
          end else begin
            a_reg <= ir;
            pc    <= pc + 1'b1;
            state <= FETCH;
          end
        end
        EXEC: begin
          r_reg  <= alu_out;
          z_flag <= zr;
          n_flag <= ng;
          state  <= WB;
        end
        WB: begin
          if (ir[DEST_A]) a_reg <= r_reg;
          if (ir[DEST_D]) d_reg <= r_reg;
          if (take) pc <= a_reg;
          else      pc <= pc + 1'b1;
          // A taken self-jump leaves pc unchanged and parks the FSM in FETCH.
          if (HALT_EN && take && (a_reg == pc)) halt_q <= 1'b1;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_ctrl.sv
// Scoreboard bench for hack_ctrl: directed Hack programs, a behavioural ALU and
// a small data memory; fetch PCs and memory writes are checked by a monitor.
module tb_hack_ctrl;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        zx, nx, zy, ny, f, no;
  logic        zr, ng;
  logic [15:0] addressM, inM, outM;
  logic        writeM;
  logic        halted;

  logic [15:0] mem [16];
  logic [15:0] pc_q [$];
  wr_t         wr_q [$];
  int          tests = 0;
  int          fails = 0;

  hack_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .zx          (zx),
    .nx          (nx),
    .zy          (zy),
    .ny          (ny),
    .f           (f),
    .no          (no),
    .alu_out     (alu_out),
    .zr          (zr),
    .ng          (ng),
    .addressM    (addressM),
    .inM         (inM),
    .outM        (outM),
    .writeM      (writeM),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Behavioural Hack ALU
  always_comb begin
    logic [15:0] x, y, o;
    x = alu_x;
    y = alu_y;
    if (zx) x = 16'h0;
    if (nx) x = ~x;
    if (zy) y = 16'h0;
    if (ny) y = ~y;
    o = f ? (x + y) : (x & y);
    if (no) o = ~o;
    alu_out = o;
    zr      = (o == 16'h0);
    ng      = o[15];
  end

  // Data memory: registered read, write on strobe
  always @(posedge clk) begin
    if (writeM) mem[addressM[3:0]] <= outM;
    inM <= mem[addressM[3:0]];
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every fetch handshake and every write strobe
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (pc_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL fetch_unexpected: got pc %h expected no fetch", pc);
      end else begin
        check("fetch_pc", pc, pc_q.pop_front());
      end
    end
    if (!reset && writeM) begin
      if (wr_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL write_unexpected: got addr %h data %h expected no write", addressM, outM);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        check("write_addr", addressM, e.addr);
        check("write_data", outM, e.data);
      end
    end
  end

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one instruction and complete its handshake; returns in DECODE.
  task automatic issue(input logic [15:0] w, input logic [15:0] exp_pc);
    int n = 0;
    pc_q.push_back(exp_pc);
    @(posedge clk); #1;
    instr       = w;
    instr_valid = 1'b1;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      tests++; fails++;
      $display("FAIL handshake_timeout: got ready 0 expected 1 for instr %h", w);
      void'(pc_q.pop_back());
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_fetch();
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      tests++; fails++;
      $display("FAIL fetch_timeout: got ready 0 expected 1");
    end
  endtask

  task automatic run(input logic [15:0] w, input logic [15:0] exp_pc);
    issue(w, exp_pc);
    wait_fetch();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    instr       = 16'h0;
    instr_valid = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_pc", pc, 16'h0000);
    check("reset_a", addressM, 16'h0000);
    check("reset_d", alu_x, 16'h0000);
    check("reset_writeM", {15'h0, writeM}, 16'h0);
    check("reset_halted", {15'h0, halted}, 16'h0);
    check("reset_ready", {15'h0, instr_ready}, 16'h1);

    // A-instruction @17, then idle fetch keeps pc
    run(16'h0011, 16'h0000);
    check("ainst_a", addressM, 16'd17);
    check("ainst_pc", pc, 16'd1);
    skip(3);
    check("idle_pc", pc, 16'd1);

    // D=A
    issue(16'hEC10, 16'd1);
    skip(2);
    check("dA_ctrl", {10'h0, zx, nx, zy, ny, f, no}, 16'b110000);
    check("dA_alu_y", alu_y, 16'd17);
    wait_fetch();
    check("dA_d", alu_x, 16'd17);
    check("dA_pc", pc, 16'd2);

    // A=5, D=9, A=5 then M=D+1
    run(16'h0005, 16'd2);
    run(16'h0009, 16'd3);
    run(16'hEC10, 16'd4);
    run(16'h0005, 16'd5);
    wr_q.push_back('{addr: 16'd5, data: 16'd10});
    issue(16'hE7C8, 16'd6);
    skip(2);
    check("mD1_ctrl", {10'h0, zx, nx, zy, ny, f, no}, 16'b011111);
    wait_fetch();
    check("mD1_a", addressM, 16'd5);
    check("mD1_d", alu_x, 16'd9);
    check("mD1_pc", pc, 16'd7);

    // D=M reads back the stored value through alu_y
    issue(16'hFC10, 16'd7);
    skip(2);
    check("dM_alu_y", alu_y, 16'd10);
    wait_fetch();
    check("dM_d", alu_x, 16'd10);

    // D;JGT taken with D=3, A=20
    run(16'h0014, 16'd8);
    run(16'h0003, 16'd9);
    run(16'hEC10, 16'd10);
    run(16'h0014, 16'd11);
    run(16'hE301, 16'd12);
    check("jgt_taken_pc", pc, 16'd20);

    // D=-1; D;JGT not taken
    run(16'hEE90, 16'd20);
    run(16'h0014, 16'd21);
    run(16'hE301, 16'd22);
    check("jgt_not_taken_pc", pc, 16'd23);

    // A=D+1;JMP jumps to the pre-write A
    run(16'h001E, 16'd23);
    run(16'h0004, 16'd24);
    run(16'hEC10, 16'd25);
    run(16'h001E, 16'd26);
    run(16'hE7E7, 16'd27);
    check("aw_jmp_pc", pc, 16'd30);
    check("aw_jmp_a", addressM, 16'd5);

    // Jump to 0xFFFF, then pc wraps to 0
    run(16'hEEA0, 16'd30);
    run(16'hEA87, 16'd31);
    check("jmp_ffff_pc", pc, 16'hFFFF);
    run(16'h0000, 16'hFFFF);
    check("wrap_pc", pc, 16'h0000);

    // Reset during EXEC of M=D+1: no write, everything back to reset values
    run(16'h0007, 16'd0);
    issue(16'hE7C8, 16'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_exec_pc", pc, 16'h0000);
    check("rst_exec_a", addressM, 16'h0000);
    check("rst_exec_d", alu_x, 16'h0000);
    check("rst_exec_ready", {15'h0, instr_ready}, 16'h1);

    // Self-jump at pc=7
    for (int i = 0; i < 7; i++) run(16'h0007, 16'(i));
    check("pre_halt_pc", pc, 16'd7);
    issue(16'hEA87, 16'd7);
`ifdef HACK_CTRL_HALT_EN
    skip(6);
    check("halt_flag", {15'h0, halted}, 16'h1);
    check("halt_pc", pc, 16'd7);
    check("halt_ready", {15'h0, instr_ready}, 16'h0);
    do_reset();
    @(negedge clk);
    check("halt_cleared", {15'h0, halted}, 16'h0);
    check("halt_reset_pc", pc, 16'h0000);
`else
    wait_fetch();
    check("selfjmp_pc", pc, 16'd7);
    check("selfjmp_halted", {15'h0, halted}, 16'h0);
    run(16'h0001, 16'd7);
    check("selfjmp_next_pc", pc, 16'd8);
    check("selfjmp_next_a", addressM, 16'd1);
`endif

    skip(2);
    check("fetch_queue_drained", 16'(pc_q.size()), 16'd0);
    check("write_queue_drained", 16'(wr_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hack_ctrl.md
# hack_ctrl

Multi-cycle Hack CPU control unit: the instruction-side counterpart of the ALU. It fetches 16-bit Hack instructions over a valid/ready handshake, owns the PC, A and D registers, and decodes C-instructions into the ALU control bits (zx, nx, zy, ny, f, no). It consumes the ALU's out/zr/ng results to perform register/memory writeback and jumps. It sits between instruction ROM, data memory and the ALU in the CPU top level.

## Interface
- Parameters:
- W, 16, data/address width; fixed to the Hack word size.
- Ports:
- clk  in  1  system clock; everything is on the rising edge
- reset  in  1  synchronous, active-high reset
- pc  out  W  instruction address (PC register)
- instr  in  W  instruction word for pc
- instr_valid  in  1  instr is valid
- instr_ready  out  1  high in FETCH; a fetch completes when instr_valid & instr_ready
- alu_x  out  W  ALU x operand, equal to D
- alu_y  out  W  ALU y operand: inM if IR[12] else A
- zx,nx,zy,ny,f,no  out  1 each  ALU controls, equal to IR[11:6] in EXEC, 0 otherwise
- alu_out  in  W  ALU result
- zr, ng  in  1 each  ALU flags
- addressM  out  W  data address, equal to the A register
- inM  in  W  data read; valid one cycle after addressM is stable
- outM  out  W  write data, registered ALU result
- writeM  out  1  one-cycle data-memory write strobe
- halted  out  1  halt flag (tied 0 without HACK_CTRL_HALT_EN)

## Operation
- States: FETCH, DECODE, EXEC, WB. Reset state is FETCH.
- FETCH: instr_ready=1. On handshake, IR<=instr and go to DECODE. Otherwise stay.
- DECODE, IR[15]=0 (A-instruction): A<=IR, pc<=pc+1, go to FETCH.
- DECODE, IR[15]=1 (C-instruction): go to EXEC. addressM=A is already stable here.
- EXEC: drive the ALU controls and alu_y. Capture R<=alu_out, Z<=zr, N<=ng. Go to WB.
- WB:
  - d1=IR[5] gives A<=R; d2=IR[4] gives D<=R; d3=IR[3] gives writeM=1 with outM=R and addressM equal to the old A.
  - Jump taken when (IR[2]&N) | (IR[1]&Z) | (IR[0]&!N&!Z).
  - If the jump is taken, pc<=old A. Otherwise pc<=pc+1.
  - Go to FETCH.
- A write and jump in the same WB both use the pre-write A, matching Hack semantics. The new A is visible from the next FETCH.
- IR[14:13] are ignored.
- pc wraps from 16'hFFFF to 0 modulo 2^W.
- Reset values: pc=0, A=0, D=0, IR=0, R=0, outM=0, writeM=0, ALU controls=0, halted=0.

## Timing
- Latency from handshake: A-instruction takes 2 cycles (FETCH, DECODE). C-instruction takes 4 cycles (FETCH, DECODE, EXEC, WB).
- With instr_valid held high, the next instr_ready rises the cycle after DECODE (A-instruction) or after WB (C-instruction).
- writeM is high only in WB and for exactly one cycle per instruction with d3=1.
- The ALU is treated as combinational: alu_out/zr/ng are sampled at the end of EXEC.
- Reset mid-instruction: the next cycle is FETCH with all reset values. The abandoned instruction has no A/D/PC/writeM effect.
- instr_valid outside FETCH is ignored; instr is not latched.

## Configuration
- HACK_CTRL_HALT_EN defined: a taken jump whose target equals the current pc sets halted=1 in WB.
  - In that case pc is unchanged and the FSM parks in FETCH with instr_ready=0.
  - Only reset clears halted.
- HACK_CTRL_HALT_EN undefined: halted is tied 0 and a self-jump loops normally.

## Structure
- hack_pkg holds:
  - the state enum;
  - IR field constants (C_BIT=15, A_BIT=12, COMP_MSB=11/COMP_LSB=6, DEST_A/D/M=5/4/3, JLT/JEQ/JGT=2/1/0);
  - WORD_W=16.
- Sub-module hack_jump_cond: combinational, takes j[2:0], zr, ng and outputs take.

## Test plan
- Reset: assert reset for 2 cycles -> pc=0, A=0, D=0, writeM=0, halted=0; instr_ready=1 in the first cycle after release.
- A-instruction: from reset, instr=16'h0011 with valid -> A=17, addressM=17, pc=1 two cycles after the handshake; valid held low in FETCH -> pc stable.
- D=A: A=17, instr=16'hEC10 -> in EXEC, controls 110000 and alu_y=17; bench ALU returns 17 -> D=17, pc=2, writeM never high.
- M=D+1: A=5, D=9, instr=16'hE7C8 -> controls 011111, bench returns 10 -> writeM for one cycle with addressM=5 and outM=10; A and D unchanged.
- Jump: A=20, D=3, instr=16'hE301 (D;JGT), zr=0, ng=0 -> pc=20. Same with ng=1 -> pc=old pc+1. Reset asserted during EXEC -> no writeback, pc=0.
- Halt (macro on): pc=7, A=7, instr=16'hEA87 -> halted=1, pc=7, instr_ready=0 until reset. With the macro off -> pc=7 and fetching continues.
